fifo_sync_param: RTL and testbench

//   Parametrised single-clock FIFO: WIDTH-bit words, DEPTH entries, push/pop handshake.

---
 rtl/fifo_sync_param_if.sv | 30 +++
 rtl/fifo_sync_param.sv | 75 +++++++
 tb/tb_fifo_sync_param.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fifo_sync_param_if.sv
// Push/pop handshake bundle for fifo_sync_param.
// The master side drives requests; the slave side is the FIFO itself.
interface fifo_sync_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic             push;
    logic [WIDTH-1:0] data_in;
    logic             pop;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, data_in, pop,
        input  data_out, empty, full, almost_full,
        input  count, overflow, underflow
    );

    modport slave (
        input  push, data_in, pop,
        output data_out, empty, full, almost_full,
        output count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock first-word-fall-through FIFO with occupancy
// count, almost-full threshold and sticky overflow/underflow flags.
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    fifo_sync_param_if.slave   bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic             ovf;
    logic             unf;
    logic             is_empty;
    logic             is_full;
    logic             push_ok;
    logic             pop_ok;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CW'(DEPTH));

    // A push into a full FIFO is legal when a pop frees the head slot
    assign push_ok = bus.push & (~is_full | bus.pop);
    assign pop_ok  = bus.pop & ~is_empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wp] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (push_ok) begin
                wp <= (wp == LAST) ? '0 : wp + PW'(1);
            end
            if (pop_ok) begin
                rp <= (rp == LAST) ? '0 : rp + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                cnt <= cnt + CW'(1);
            end else if (pop_ok && !push_ok) begin
                cnt <= cnt - CW'(1);
            end
            if (bus.push && is_full && !bus.pop) begin
                ovf <= 1'b1;
            end
            if (bus.pop && is_empty) begin
                unf <= 1'b1;
            end
        end
    end

    assign bus.data_out    = is_empty ? '0 : mem[rp];
    assign bus.empty       = is_empty;
    assign bus.full        = is_full;
    assign bus.almost_full = (cnt >= CW'(AF_LEVEL));
    assign bus.count       = cnt;
    assign bus.overflow    = ovf;
    assign bus.underflow   = unf;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: DEPTH=16 and DEPTH=5 instances driven in
// lockstep and compared against queue-based reference models.
module tb_fifo_sync_param;
    logic clk;
    logic rst;

    fifo_sync_param_if #(.WIDTH(8), .DEPTH(16)) b16 ();
    fifo_sync_param_if #(.WIDTH(8), .DEPTH(5))  b5 ();

    fifo_sync_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12)) u16 (
        .clk(clk), .rst(rst), .bus(b16)
    );
    fifo_sync_param #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4)) u5 (
        .clk(clk), .rst(rst), .bus(b5)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    logic [7:0] q16[$];
    logic [7:0] q5[$];
    bit ov16, un16, ov5, un5;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int s16, s5;
        s16 = q16.size();
        s5  = q5.size();
        check({tag, " cnt16"}, 32'(b16.count), s16);
        check({tag, " emp16"}, 32'(b16.empty), 32'(s16 == 0));
        check({tag, " ful16"}, 32'(b16.full), 32'(s16 == 16));
        check({tag, " af16"}, 32'(b16.almost_full), 32'(s16 >= 12));
        check({tag, " dout16"}, 32'(b16.data_out),
              (s16 == 0) ? 32'h0 : 32'(q16[0]));
        check({tag, " ovf16"}, 32'(b16.overflow), 32'(ov16));
        check({tag, " unf16"}, 32'(b16.underflow), 32'(un16));
        check({tag, " cnt5"}, 32'(b5.count), s5);
        check({tag, " emp5"}, 32'(b5.empty), 32'(s5 == 0));
        check({tag, " ful5"}, 32'(b5.full), 32'(s5 == 5));
        check({tag, " af5"}, 32'(b5.almost_full), 32'(s5 >= 4));
        check({tag, " dout5"}, 32'(b5.data_out),
              (s5 == 0) ? 32'h0 : 32'(q5[0]));
        check({tag, " ovf5"}, 32'(b5.overflow), 32'(ov5));
        check({tag, " unf5"}, 32'(b5.underflow), 32'(un5));
    endtask

    // One clock of identical stimulus to both FIFOs, models updated from
    // the pre-edge occupancy, outputs checked just after the edge.
    task automatic step(input bit p, input logic [7:0] d, input bit q,
                        input string tag);
        bit f, e;
        b16.push = p; b16.data_in = d; b16.pop = q;
        b5.push  = p; b5.data_in  = d; b5.pop  = q;
        f = (q16.size() == 16);
        e = (q16.size() == 0);
        if (p && f && !q) ov16 = 1;
        if (q && e) un16 = 1;
        if (q && !e) void'(q16.pop_front());
        if (p && (!f || q)) q16.push_back(d);
        f = (q5.size() == 5);
        e = (q5.size() == 0);
        if (p && f && !q) ov5 = 1;
        if (q && e) un5 = 1;
        if (q && !e) void'(q5.pop_front());
        if (p && (!f || q)) q5.push_back(d);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        q16.delete();
        q5.delete();
        ov16 = 0; un16 = 0; ov5 = 0; un5 = 0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clk = 0;
        rst = 1;
        b16.push = 0; b16.pop = 0; b16.data_in = '0;
        b5.push  = 0; b5.pop  = 0; b5.data_in  = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 0;

        for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, "fill");
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, "drain");

        for (int i = 1; i <= 16; i++) step(1, 8'(i + 32), 0, "fill2");
        step(1, 8'hAA, 0, "ovf");
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, "drain2");

        for (int i = 1; i <= 16; i++) step(1, 8'(i + 64), 0, "fill3");
        step(1, 8'h77, 1, "pp_full");
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, "drain3");
        step(1, 8'h99, 1, "pp_empty");
        step(0, 8'h00, 1, "pp_pop");

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) step(1, 8'(16 * r + i + 1), 0, "wr_push");
            for (int i = 0; i < 4; i++) step(0, 8'h00, 1, "wr_pop");
        end

        for (int i = 0; i < 7; i++) step(1, 8'(i + 200), 0, "pre_rst");
        check("pre_rst cnt16", 32'(b16.count), 32'd7);
        @(negedge clk);
        rst = 1;
        #1;
        model_reset();
        check_all("mid_rst");
        @(negedge clk);
        rst = 0;
        step(1, 8'h55, 0, "post_rst");
        check("post_rst dout", 32'(b16.data_out), 32'h55);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 55), 8'($urandom),
                 1'($urandom_range(0, 99) < 45), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
